pipe_stage_reg: RTL and testbench

Parametrised, elastic successor to the fixed inter-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries a control field and a data field between two pipeline stages. It uses a valid/ready handshake and a 2-entry skid buffer, so that `ready_o` is fully registered. A synchronous flush squashes all in-flight beats into bubbles (control field zeroed) and counts the squashed beats.

---
 rtl/pipe_stage_reg.sv | 116 +++++++++++
 tb/tb_pipe_stage_reg.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Elastic inter-stage pipeline register: valid/ready handshake with a 2-entry skid buffer,
// synchronous flush to bubbles, and a saturating count of flushed beats.
module pipe_stage_reg #(
    parameter int CTRL_W = 6,
    parameter int DATA_W = 101,
    parameter int CNT_W  = 8
) (
    input  logic              clk_i,
    input  logic              rst_n,
    input  logic              valid_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              ready_o,
    output logic              valid_o,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [DATA_W-1:0] data_o,
    input  logic              ready_i,
    input  logic              flush_i,
    output logic [CNT_W-1:0]  flush_cnt_o
);

    // Encoding doubles as occupancy (0/1/2 held beats).
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_FULL  = 2'd1,
        S_SKID  = 2'd2
    } state_t;

    localparam logic [CNT_W+1:0] CNT_MAX = {2'b00, {CNT_W{1'b1}}};

    state_t              r_state;
    logic [CTRL_W-1:0]   r_main_ctrl;
    logic [DATA_W-1:0]   r_main_data;
    logic [CTRL_W-1:0]   r_skid_ctrl;
    logic [DATA_W-1:0]   r_skid_data;
    logic [CNT_W-1:0]    r_flush_cnt;

    logic                w_in_xfer;
    logic                w_out_xfer;
    logic [1:0]          w_occ;
    logic [CNT_W+1:0]    w_sum;

    function automatic logic [CNT_W-1:0] sat_cnt(input logic [CNT_W+1:0] sum);
        if (sum > CNT_MAX) begin
            return {CNT_W{1'b1}};
        end
        return sum[CNT_W-1:0];
    endfunction

    assign ready_o     = (r_state != S_SKID);
    assign valid_o     = (r_state != S_EMPTY);
    assign ctrl_o      = r_main_ctrl;
    assign data_o      = r_main_data;
    assign flush_cnt_o = r_flush_cnt;

    assign w_in_xfer  = valid_i & ready_o;
    assign w_out_xfer = valid_o & ready_i;
    assign w_occ      = r_state;

    // Occupancy never falls below the out-transfer, so the sum cannot underflow.
    assign w_sum = {2'b00, r_flush_cnt}
                 + {{CNT_W{1'b0}}, w_occ}
                 - {{(CNT_W+1){1'b0}}, w_out_xfer}
                 + {{(CNT_W+1){1'b0}}, w_in_xfer};

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_EMPTY;
            r_main_ctrl <= '0;
            r_main_data <= '0;
            r_skid_ctrl <= '0;
            r_skid_data <= '0;
            r_flush_cnt <= '0;
        end else if (flush_i) begin
            r_state     <= S_EMPTY;
            r_main_ctrl <= '0;
            r_skid_ctrl <= '0;
            r_flush_cnt <= sat_cnt(w_sum);
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_in_xfer) begin
                        r_main_ctrl <= ctrl_i;
                        r_main_data <= data_i;
                        r_state     <= S_FULL;
                    end
                end
                S_FULL: begin
                    if (w_in_xfer && w_out_xfer) begin
                        r_main_ctrl <= ctrl_i;
                        r_main_data <= data_i;
                    end else if (w_in_xfer) begin
                        r_skid_ctrl <= ctrl_i;
                        r_skid_data <= data_i;
                        r_state     <= S_SKID;
                    end else if (w_out_xfer) begin
                        r_main_ctrl <= '0;
                        r_state     <= S_EMPTY;
                    end
                end
                S_SKID: begin
                    if (w_out_xfer) begin
                        r_main_ctrl <= r_skid_ctrl;
                        r_main_data <= r_skid_data;
                        r_skid_ctrl <= '0;
                        r_state     <= S_FULL;
                    end
                end
                default: begin
                    r_state <= S_EMPTY;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: streaming, skid backpressure, flush cases,
// counter saturation (CNT_W=2 instance) and asynchronous reset.
module tb_pipe_stage_reg;

    localparam int CTRL_W = 6;
    localparam int DATA_W = 101;

    logic              clk_i = 1'b0;
    logic              rst_n;
    logic              valid_i;
    logic [CTRL_W-1:0] ctrl_i;
    logic [DATA_W-1:0] data_i;
    logic              ready_i;
    logic              flush_i;

    logic              ready_o,  valid_o;
    logic [CTRL_W-1:0] ctrl_o;
    logic [DATA_W-1:0] data_o;
    logic [7:0]        flush_cnt_o;

    logic              s_ready_o, s_valid_o;
    logic [CTRL_W-1:0] s_ctrl_o;
    logic [DATA_W-1:0] s_data_o;
    logic [1:0]        s_flush_cnt_o;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk_i = ~clk_i;

    pipe_stage_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CNT_W(8)) dut (
        .clk_i(clk_i), .rst_n(rst_n), .valid_i(valid_i), .ctrl_i(ctrl_i), .data_i(data_i),
        .ready_o(ready_o), .valid_o(valid_o), .ctrl_o(ctrl_o), .data_o(data_o),
        .ready_i(ready_i), .flush_i(flush_i), .flush_cnt_o(flush_cnt_o)
    );

    pipe_stage_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CNT_W(2)) dut_s (
        .clk_i(clk_i), .rst_n(rst_n), .valid_i(valid_i), .ctrl_i(ctrl_i), .data_i(data_i),
        .ready_o(s_ready_o), .valid_o(s_valid_o), .ctrl_o(s_ctrl_o), .data_o(s_data_o),
        .ready_i(ready_i), .flush_i(flush_i), .flush_cnt_o(s_flush_cnt_o)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic v, input logic [CTRL_W-1:0] c, input int d,
                         input logic rdy, input logic fl);
        valid_i = v;
        ctrl_i  = c;
        data_i  = DATA_W'(d);
        ready_i = rdy;
        flush_i = fl;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(1'b0, '0, 0, 1'b0, 1'b0);
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, '0, 0, 1'b0, 1'b0);
        repeat (3) step();
        check("rst_valid", valid_o, 0);
        check("rst_ready", ready_o, 1);
        check("rst_ctrl", ctrl_o, 0);
        check("rst_data", data_o, 0);
        check("rst_cnt", flush_cnt_o, 0);
        rst_n = 1'b1;

        // Streaming: each beat visible one cycle after acceptance, no gaps.
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 6'h3F, i, 1'b1, 1'b0);
            step();
            check("strm_valid", valid_o, 1);
            check("strm_data", data_o, i);
            check("strm_ctrl", ctrl_o, 6'h3F);
        end
        drive(1'b0, '0, 0, 1'b1, 1'b0);
        step();
        check("drain_valid", valid_o, 0);
        check("drain_ctrl", ctrl_o, 0);
        check("drain_data_hold", data_o, 8);

        // Skid backpressure.
        drive(1'b1, 6'h11, 1, 1'b1, 1'b0);
        step();
        check("skid_b1", data_o, 1);
        drive(1'b1, 6'h12, 2, 1'b0, 1'b0);
        step();
        check("skid_ready_lo", ready_o, 0);
        check("skid_hold_b1", data_o, 1);
        drive(1'b1, 6'h13, 3, 1'b0, 1'b0);
        step();
        check("skid_hold2", data_o, 1);
        step();
        check("skid_hold3", data_o, 1);
        check("skid_ready_lo3", ready_o, 0);
        drive(1'b1, 6'h13, 3, 1'b1, 1'b0);
        step();
        check("skid_b2", data_o, 2);
        check("skid_b2_ctrl", ctrl_o, 6'h12);
        check("skid_ready_hi", ready_o, 1);
        step();
        check("skid_b3", data_o, 3);
        drive(1'b1, 6'h14, 4, 1'b1, 1'b0);
        step();
        check("skid_b4", data_o, 4);
        drive(1'b0, '0, 0, 1'b1, 1'b0);
        step();
        check("skid_empty", valid_o, 0);

        // Flush in SKID: A in main, B in skid, C offered but not accepted.
        drive(1'b1, 6'h21, 'hA, 1'b0, 1'b0);
        step();
        drive(1'b1, 6'h22, 'hB, 1'b0, 1'b0);
        step();
        check("fs_skid", ready_o, 0);
        drive(1'b1, 6'h23, 'hC, 1'b0, 1'b1);
        step();
        check("fs_valid", valid_o, 0);
        check("fs_ctrl", ctrl_o, 0);
        check("fs_ready", ready_o, 1);
        check("fs_cnt", flush_cnt_o, 2);
        check("fs_data_keep", data_o, 'hA);
        check("fs_cnt_s", s_flush_cnt_o, 2);

        // Flush with out-transfer: A delivered, D dropped.
        drive(1'b1, 6'h24, 'hAA, 1'b1, 1'b0);
        step();
        drive(1'b1, 6'h25, 'hD, 1'b1, 1'b1);
        check("fo_a_valid", valid_o, 1);
        check("fo_a_data", data_o, 'hAA);
        step();
        check("fo_valid", valid_o, 0);
        check("fo_ready", ready_o, 1);
        check("fo_cnt", flush_cnt_o, 3);
        check("fo_cnt_s", s_flush_cnt_o, 3);
        drive(1'b0, '0, 0, 1'b1, 1'b0);
        step();
        check("fo_still_empty", valid_o, 0);

        // Saturation on the CNT_W=2 instance.
        do_reset();
        check("sat_rst_cnt_s", s_flush_cnt_o, 0);
        for (int k = 1; k <= 3; k++) begin
            drive(1'b1, 6'h31, 'h100 + k, 1'b0, 1'b0);
            step();
            drive(1'b1, 6'h32, 'h200 + k, 1'b0, 1'b0);
            step();
            drive(1'b0, '0, 0, 1'b0, 1'b1);
            step();
            check("sat_cnt_big", flush_cnt_o, 2 * k);
            check("sat_cnt_small", s_flush_cnt_o, (k == 1) ? 2 : 3);
        end
        drive(1'b0, '0, 0, 1'b0, 1'b0);

        // Asynchronous reset while in SKID.
        drive(1'b1, 6'h3A, 'h55, 1'b0, 1'b0);
        step();
        drive(1'b1, 6'h3B, 'h66, 1'b0, 1'b0);
        step();
        check("ar_skid", ready_o, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_valid", valid_o, 0);
        check("ar_ready", ready_o, 1);
        check("ar_ctrl", ctrl_o, 0);
        check("ar_data", data_o, 0);
        check("ar_cnt", flush_cnt_o, 0);
        step();
        rst_n = 1'b1;
        drive(1'b1, 6'h07, 'h77, 1'b1, 1'b0);
        step();
        check("ar_first_beat", data_o, 'h77);
        check("ar_first_ctrl", ctrl_o, 6'h07);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
